// File: rtl/ped_pkg.sv
// ped_pkg
//   Shared constants for the pedestrian crossing slice: system tick rate,
//   button active level, debounce channel state encoding and the default
//   debounce / stuck-button windows used by both this conditioner and the
//   crossing controller.
package ped_pkg;

  localparam int       CLK_HZ        = 1000;
  localparam logic     BTN_ACT       = 1'b0;
  localparam int       DB_CNT_DEF    = 20;
  localparam int       STUCK_CNT_DEF = 15000;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    CHKP = 2'd1,
    PRS  = 2'd2,
    CHKR = 2'd3
  } chan_state_e;

  // A channel counts as held from the moment the press is qualified until
  // the release has been qualified, so CHKR still reads as held.
  function automatic logic is_held(input chan_state_e st);
    return (st == PRS) || (st == CHKR);
  endfunction

endpackage

// File: rtl/ped_db_chan.sv
// ped_db_chan
//   One pushbutton channel: 2-FF synchroniser, REL/CHKP/PRS/CHKR debounce
//   FSM with an 8-bit window counter, and (with PED_STUCK_DET_EN defined) a
//   16-bit hold counter that masks a button held for STUCK_CNT cycles.
// Ports
//   clk        system tick, rising edge
//   rst        asynchronous reset, active-high
//   btn_n      raw active-low button, asynchronous to clk
//   level_n    registered debounced level, active-low (forced high when stuck)
//   enter_prs  one-cycle strobe on a newly qualified press
//   stuck_ch   channel held beyond STUCK_CNT (constant 0 without the macro)
// Configuration macro: PED_STUCK_DET_EN
module ped_db_chan
  import ped_pkg::*;
#(
  parameter int DB_CNT    = DB_CNT_DEF,
  parameter int STUCK_CNT = STUCK_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level_n,
  output logic enter_prs,
  output logic stuck_ch
);

  localparam logic [7:0] DB_LAST = 8'(DB_CNT - 1);

  if (DB_CNT < 2 || DB_CNT > 255 || STUCK_CNT <= DB_CNT || STUCK_CNT > 65535) begin : g_param_check
    $error("ped_db_chan: DB_CNT/STUCK_CNT out of legal range");
  end

  logic        s0, s1;
  chan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        held_d;
  logic        new_press;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      s0 <= btn_n;
      s1 <= s0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REL;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any disagreement with the current candidate level sends the FSM back,
  // so a qualified change needs DB_CNT unbroken samples after detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      REL: begin
        if (s1 == BTN_ACT) begin
          state_d = CHKP;
          cnt_d   = 8'd0;
        end
      end
      CHKP: begin
        if (s1 != BTN_ACT) begin
          state_d = REL;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRS;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PRS: begin
        if (s1 != BTN_ACT) begin
          state_d = CHKR;
          cnt_d   = 8'd0;
        end
      end
      CHKR: begin
        if (s1 == BTN_ACT) begin
          state_d = PRS;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LAST) begin
          state_d = REL;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Only CHKP->PRS is a new press; a release bounce back into PRS is not.
  assign held_d    = is_held(state_d);
  assign new_press = (state_q == CHKP) && (state_d == PRS);

`ifdef PED_STUCK_DET_EN
  localparam logic [15:0] STUCK_L = 16'(STUCK_CNT);

  logic [15:0] hold_q, hold_d;
  logic        masked_d;

  // Hold time restarts at zero on the qualifying edge and sticks at the
  // limit, so the mask holds until the FSM is back in REL.
  always_comb begin
    hold_d = 16'd0;
    if (held_d && is_held(state_q)) begin
      hold_d = (hold_q == STUCK_L) ? hold_q : hold_q + 16'd1;
    end
  end

  assign masked_d = (hold_d == STUCK_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= 16'd0;
      level_n   <= 1'b1;
      enter_prs <= 1'b0;
      stuck_ch  <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      level_n   <= ~(held_d & ~masked_d);
      enter_prs <= new_press & ~masked_d;
      stuck_ch  <= masked_d;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_n   <= 1'b1;
      enter_prs <= 1'b0;
    end else begin
      level_n   <= ~held_d;
      enter_prs <= new_press;
    end
  end

  assign stuck_ch = 1'b0;
`endif

endmodule

// File: rtl/ped_btn_cond.sv
// ped_btn_cond
//   Pedestrian push-button conditioner feeding the crossing controller.
//   Two independent debounce channels; press strobes and stuck flags are
//   merged so simultaneous presses give one pulse.
// Ports
//   clk        1 kHz system tick, rising edge
//   rst        asynchronous reset, active-high
//   btn1_n     raw pushbutton 1, active-low
//   btn2_n     raw pushbutton 2, active-low
//   req1_n     debounced button 1 level, active-low
//   req2_n     debounced button 2 level, active-low
//   press_pls  one-cycle pulse on any newly qualified press
//   stuck      some channel held beyond STUCK_CNT
// Configuration macro: PED_STUCK_DET_EN (stuck-button detection and masking)
module ped_btn_cond
  import ped_pkg::*;
#(
  parameter int DB_CNT    = DB_CNT_DEF,
  parameter int STUCK_CNT = STUCK_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_n,
  input  logic btn2_n,
  output logic req1_n,
  output logic req2_n,
  output logic press_pls,
  output logic stuck
);

  logic enter1, enter2;
  logic stuck1, stuck2;

  ped_db_chan #(.DB_CNT(DB_CNT), .STUCK_CNT(STUCK_CNT)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn1_n),
    .level_n   (req1_n),
    .enter_prs (enter1),
    .stuck_ch  (stuck1)
  );

  ped_db_chan #(.DB_CNT(DB_CNT), .STUCK_CNT(STUCK_CNT)) u_chan2 (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn2_n),
    .level_n   (req2_n),
    .enter_prs (enter2),
    .stuck_ch  (stuck2)
  );

  // Both strobes are registered, so the OR stays glitch-free.
  assign press_pls = enter1 | enter2;
  assign stuck     = stuck1 | stuck2;

endmodule

// File: tb/tb_ped_btn_cond.sv
// tb_ped_btn_cond
//   Directed and random stimulus for ped_btn_cond, compared every cycle
//   against a run-length model of the debounce rules.
module tb_ped_btn_cond;

  localparam int DB = 20;
  localparam int ST = 100;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn1_n = 1'b1;
  logic btn2_n = 1'b1;
  logic req1_n, req2_n, press_pls, stuck;

  ped_btn_cond #(.DB_CNT(DB), .STUCK_CNT(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn1_n    (btn1_n),
    .btn2_n    (btn2_n),
    .req1_n    (req1_n),
    .req2_n    (req2_n),
    .press_pls (press_pls),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: a channel flips once its synchronised input has disagreed with
  // the debounced level for DB+1 consecutive sampled edges.
  bit hist[2][$];
  int run[2];
  bit pressed[2];
  int hold[2];
  bit exp_pls;

  // Edge bookkeeping on the observed outputs.
  logic prev1, prev2;
  int fall1, fall2, rise1, rise2, pls_cnt;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      hist[c].delete();
      hist[c].push_back(1'b1);
      hist[c].push_back(1'b1);
      run[c] = 0;
      pressed[c] = 1'b0;
      hold[c] = 0;
    end
    exp_pls = 1'b0;
  endfunction

  function automatic void model_edge(input bit r1, input bit r2);
    bit raw[2];
    bit obs, was, want;
    raw[0] = r1;
    raw[1] = r2;
    exp_pls = 1'b0;
    for (int c = 0; c < 2; c++) begin
      obs = hist[c][0];
      void'(hist[c].pop_front());
      hist[c].push_back(raw[c]);
      was = pressed[c];
      want = (obs == 1'b0);
      if (want != pressed[c]) begin
        run[c]++;
        if (run[c] == DB + 1) begin
          pressed[c] = want;
          run[c] = 0;
          if (want) exp_pls = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
      if (pressed[c] && was) hold[c] = (hold[c] < ST) ? hold[c] + 1 : ST;
      else hold[c] = 0;
    end
  endfunction

  function automatic logic exp_req(input int c);
`ifdef PED_STUCK_DET_EN
    return !(pressed[c] && hold[c] != ST);
`else
    return !pressed[c];
`endif
  endfunction

  function automatic logic exp_stuck();
`ifdef PED_STUCK_DET_EN
    return (pressed[0] && hold[0] == ST) || (pressed[1] && hold[1] == ST);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    chk("req1_n", req1_n, exp_req(0));
    chk("req2_n", req2_n, exp_req(1));
    chk("press_pls", press_pls, exp_pls);
    chk("stuck", stuck, exp_stuck());
    if (prev1 === 1'b1 && req1_n === 1'b0) fall1 = cyc;
    if (prev2 === 1'b1 && req2_n === 1'b0) fall2 = cyc;
    if (prev1 === 1'b0 && req1_n === 1'b1) rise1 = cyc;
    if (prev2 === 1'b0 && req2_n === 1'b1) rise2 = cyc;
    if (press_pls === 1'b1) pls_cnt++;
    prev1 = req1_n;
    prev2 = req2_n;
  endtask

  // Inputs change on the falling edge; the next rising edge is the first
  // one that can sample them, and that edge is numbered cyc+1.
  task automatic apply_stimulus(input bit b1, input bit b2, input bit r);
    @(negedge clk);
    btn1_n = b1;
    btn2_n = b2;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else model_edge(b1, b2);
    #1;
    check_output();
  endtask

  task automatic repeat_stim(input bit b1, input bit b2, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(b1, b2, 1'b0);
  endtask

  task automatic clear_marks();
    fall1 = -1;
    fall2 = -1;
    rise1 = -1;
    rise2 = -1;
    pls_cnt = 0;
  endtask

  initial begin
    int t0;
    bit rb1, rb2;
    model_reset();
    prev1 = 1'b1;
    prev2 = 1'b1;
    clear_marks();

    // Reset held with buttons released.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b1);

    // Single press on button 1.
    clear_marks();
    t0 = cyc + 1;
    repeat_stim(1'b0, 1'b1, 50);
    chk_int("lat_press1", fall1, t0 + LAT);
    chk_int("pls_press1", pls_cnt, 1);
    chk_int("req2_quiet", fall2, -1);
    repeat_stim(1'b1, 1'b1, 40);

    // Bounced press: only the final steady low counts.
    clear_marks();
    repeat_stim(1'b0, 1'b1, 5);
    repeat_stim(1'b1, 1'b1, 3);
    repeat_stim(1'b0, 1'b1, 5);
    repeat_stim(1'b1, 1'b1, 2);
    t0 = cyc + 1;
    repeat_stim(1'b0, 1'b1, 40);
    chk_int("lat_bounce", fall1, t0 + LAT);
    chk_int("pls_bounce", pls_cnt, 1);
    repeat_stim(1'b1, 1'b1, 40);

    // Both buttons together: one pulse, matching edges both ways.
    clear_marks();
    t0 = cyc + 1;
    repeat_stim(1'b0, 1'b0, 40);
    chk_int("lat_both1", fall1, t0 + LAT);
    chk_int("lat_both2", fall2, t0 + LAT);
    chk_int("pls_both", pls_cnt, 1);
    clear_marks();
    t0 = cyc + 1;
    repeat_stim(1'b1, 1'b1, 40);
    chk_int("rel_both1", rise1, t0 + LAT);
    chk_int("rel_both2", rise2, t0 + LAT);
    chk_int("pls_release", pls_cnt, 0);

    // Long hold on button 2.
    clear_marks();
    repeat_stim(1'b1, 1'b0, 200);
`ifdef PED_STUCK_DET_EN
    chk("hold_req2", req2_n, 1'b1);
    chk("hold_stuck", stuck, 1'b1);
`else
    chk("hold_req2", req2_n, 1'b0);
    chk("hold_stuck", stuck, 1'b0);
`endif
    repeat_stim(1'b1, 1'b1, 40);
    chk("after_hold_stuck", stuck, 1'b0);
    chk("after_hold_req2", req2_n, 1'b1);

    // Reset mid-press: asynchronous clear, then full re-qualification.
    repeat_stim(1'b0, 1'b1, 40);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req1", req1_n, 1'b1);
    chk("async_pls", press_pls, 1'b0);
    model_reset();
    prev1 = req1_n;
    prev2 = req2_n;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b1);
    clear_marks();
    t0 = cyc + 1;
    repeat_stim(1'b0, 1'b1, 30);
    chk_int("lat_after_rst", fall1, t0 + LAT);
    repeat_stim(1'b1, 1'b1, 30);

    // Random bursts of mixed button activity.
    for (int b = 0; b < 40; b++) begin
      rb1 = 1'($urandom_range(0, 1));
      rb2 = 1'($urandom_range(0, 1));
      repeat_stim(rb1, rb2, $urandom_range(1, 35));
    end
    repeat_stim(1'b1, 1'b1, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
